// File: rtl/mips_pkg.sv
// Shared types and widths for the MIPS memory stage.
package mips_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  localparam int WORD_W     = 32;
  localparam int REG_ADDR_W = 5;

  function automatic logic isWordAligned(input logic [1:0] lowBits);
    return (lowBits == 2'b00);
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads on i_load, inserts a bubble on i_bubble.
module mem_wb_reg
  import mips_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  i_load,
  input  logic                  i_bubble,
  input  logic [WORD_W-1:0]     i_instr,
  input  logic [WORD_W-1:0]     i_pc,
  input  logic                  i_regWrite,
  input  logic                  i_memToReg,
  input  logic [REG_ADDR_W-1:0] i_writeReg,
  input  logic [WORD_W-1:0]     i_result,
  input  logic [WORD_W-1:0]     i_readData,
  output logic [WORD_W-1:0]     o_instr,
  output logic [WORD_W-1:0]     o_pc,
  output logic                  o_regWrite,
  output logic                  o_memToReg,
  output logic [REG_ADDR_W-1:0] o_writeReg,
  output logic [WORD_W-1:0]     o_result,
  output logic [WORD_W-1:0]     o_readData,
  output logic                  o_valid
);

  logic [WORD_W-1:0]     r_instr;
  logic [WORD_W-1:0]     r_pc;
  logic                  r_regWrite;
  logic                  r_memToReg;
  logic [REG_ADDR_W-1:0] r_writeReg;
  logic [WORD_W-1:0]     r_result;
  logic [WORD_W-1:0]     r_readData;
  logic                  r_valid;

  // A bubble only kills the side-effecting fields; the payload is left as is.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_instr    <= '0;
      r_pc       <= '0;
      r_regWrite <= 1'b0;
      r_memToReg <= 1'b0;
      r_writeReg <= '0;
      r_result   <= '0;
      r_readData <= '0;
      r_valid    <= 1'b0;
    end else if (i_bubble) begin
      r_regWrite <= 1'b0;
      r_memToReg <= 1'b0;
      r_valid    <= 1'b0;
    end else if (i_load) begin
      r_instr    <= i_instr;
      r_pc       <= i_pc;
      r_regWrite <= i_regWrite;
      r_memToReg <= i_memToReg;
      r_writeReg <= i_writeReg;
      r_result   <= i_result;
      r_readData <= i_readData;
      r_valid    <= 1'b1;
    end
  end

  assign o_instr    = r_instr;
  assign o_pc       = r_pc;
  assign o_regWrite = r_regWrite;
  assign o_memToReg = r_memToReg;
  assign o_writeReg = r_writeReg;
  assign o_result   = r_result;
  assign o_readData = r_readData;
  assign o_valid    = r_valid;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: drives the req/ack data-memory bus, stalls EX/MEM while an
// access is outstanding, aborts on timeout and resolves branch/jump redirects.
module mem_stage_ctrl
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int ADDR_W  = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [WORD_W-1:0]     iInstr,
  input  logic                  iRegWrite,
  input  logic                  iMemRead,
  input  logic                  iMemWrite,
  input  logic                  iMemToReg,
  input  logic                  iBranch,
  input  logic                  iJump,
  input  logic                  iZero,
  input  logic [WORD_W-1:0]     iB,
  input  logic [WORD_W-1:0]     iResult,
  input  logic [WORD_W-1:0]     inextPCBranch,
  input  logic [WORD_W-1:0]     iNPC1,
  input  logic [WORD_W-1:0]     iPC,
  input  logic [REG_ADDR_W-1:0] iwriteRegWire,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [WORD_W-1:0]     mem_wdata,
  input  logic [WORD_W-1:0]     mem_rdata,
  input  logic                  mem_ack,
  output logic                  stall,
  output logic                  pc_redirect,
  output logic [WORD_W-1:0]     pc_target,
  output logic [WORD_W-1:0]     oInstr,
  output logic [WORD_W-1:0]     oPC,
  output logic                  oRegWrite,
  output logic                  oMemToReg,
  output logic [REG_ADDR_W-1:0] owriteRegWire,
  output logic [WORD_W-1:0]     oResult,
  output logic [WORD_W-1:0]     oReadData,
  output logic                  oValid,
  output logic                  err_timeout,
  output logic                  err_align
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  mem_state_t        r_state;
  logic [CNT_W-1:0]  r_count;
  logic              r_memReq;
  logic              r_memWe;
  logic [ADDR_W-1:0] r_memAddr;
  logic [WORD_W-1:0] r_memWdata;
  logic              r_errTimeout;
  logic              r_errAlign;

  logic              w_memOp;
  logic              w_issue;
  logic              w_misalign;
  logic [CNT_W-1:0]  w_countNext;
  logic              w_ackDone;
  logic              w_timeout;
  logic              w_done;
  logic              w_stall;
  logic              w_taken;
  logic              w_wbRegWrite;
  logic [WORD_W-1:0] w_wbReadData;

  assign w_memOp     = iMemRead | iMemWrite;
  assign w_issue     = (r_state == IDLE) && w_memOp && isWordAligned(iResult[1:0]);
  assign w_misalign  = (r_state == IDLE) && w_memOp && !isWordAligned(iResult[1:0]);
  assign w_countNext = r_count + CNT_W'(1);
  // An ack in the final ACCESS cycle wins over the timeout.
  assign w_ackDone   = (r_state == ACCESS) && mem_ack;
  assign w_timeout   = (r_state == ACCESS) && !mem_ack && (w_countNext == CNT_W'(TIMEOUT));
  assign w_done      = w_ackDone | w_timeout;
  assign w_stall     = w_issue | ((r_state == ACCESS) && !w_done);

  assign w_wbRegWrite = iRegWrite & ~w_misalign & ~w_timeout;
  assign w_wbReadData = (w_ackDone && iMemRead && !iMemWrite) ? mem_rdata : '0;

  assign w_taken     = iBranch & iZero;
  assign pc_redirect = w_taken | iJump;
  assign pc_target   = w_taken ? inextPCBranch : iResult;
  assign stall       = w_stall;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_memReq     <= 1'b0;
      r_memWe      <= 1'b0;
      r_memAddr    <= '0;
      r_memWdata   <= '0;
      r_errTimeout <= 1'b0;
      r_errAlign   <= 1'b0;
    end else if (r_state == IDLE) begin
      if (w_issue) begin
        r_state    <= ACCESS;
        r_count    <= '0;
        r_memReq   <= 1'b1;
        r_memWe    <= iMemWrite;
        r_memAddr  <= iResult[ADDR_W-1:0];
        r_memWdata <= iB;
      end
      if (w_misalign) begin
        r_errAlign <= 1'b1;
      end
    end else begin
      if (w_done) begin
        r_state  <= IDLE;
        r_count  <= '0;
        r_memReq <= 1'b0;
      end else begin
        r_count <= w_countNext;
      end
      if (w_timeout) begin
        r_errTimeout <= 1'b1;
      end
    end
  end

  assign mem_req     = r_memReq;
  assign mem_we      = r_memWe;
  assign mem_addr    = r_memAddr;
  assign mem_wdata   = r_memWdata;
  assign err_timeout = r_errTimeout;
  assign err_align   = r_errAlign;

  mem_wb_reg u_memWb (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_load     (~w_stall),
    .i_bubble   (w_stall),
    .i_instr    (iInstr),
    .i_pc       (iPC),
    .i_regWrite (w_wbRegWrite),
    .i_memToReg (iMemToReg),
    .i_writeReg (iwriteRegWire),
    .i_result   (iResult),
    .i_readData (w_wbReadData),
    .o_instr    (oInstr),
    .o_pc       (oPC),
    .o_regWrite (oRegWrite),
    .o_memToReg (oMemToReg),
    .o_writeReg (owriteRegWire),
    .o_result   (oResult),
    .o_readData (oReadData),
    .o_valid    (oValid)
  );

  logic w_unusedNpc;
  assign w_unusedNpc = ^iNPC1;

endmodule
